// File: rtl/riscy_mem_pkg.sv
// Shared types and helpers for the RISCY data-memory responder.
package riscy_mem_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } gnt_state_e;

  localparam int unsigned GNT_WAIT_MIN = 0;
  localparam int unsigned GNT_WAIT_MAX = 7;
  localparam int unsigned RSP_LAT_MIN  = 1;
  localparam int unsigned RSP_LAT_MAX  = 4;

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/riscy_mem_rsp_pipe.sv
// Fixed-latency response shift register with asynchronous clear.
module riscy_mem_rsp_pipe
  import riscy_mem_pkg::*;
#(
  parameter int unsigned RSP_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_ni,
  input  mem_rsp_t i_rsp,
  output mem_rsp_t o_rsp
);

  mem_rsp_t [RSP_LAT-1:0] r_stage;

  if (RSP_LAT == 1) begin : g_one
    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) r_stage <= '0;
      else         r_stage[0] <= i_rsp;
    end
  end else begin : g_many
    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) r_stage <= '0;
      else         r_stage <= {r_stage[RSP_LAT-2:0], i_rsp};
    end
  end

  assign o_rsp = r_stage[RSP_LAT-1];

endmodule

// File: rtl/riscy_obi_mem_responder.sv
// Request/grant/rvalid data-memory responder with byte-enable RAM, backdoor
// preload and a store observation port.
module riscy_obi_mem_responder
  import riscy_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned GNT_WAIT   = 0,
  parameter int unsigned RSP_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  input  logic                  init_we_i,
  input  logic [DEPTH_LOG2-1:0] init_addr_i,
  input  logic [31:0]           init_wdata_i,
  output logic                  st_valid_o,
  output logic [31:0]           st_addr_o,
  output logic [31:0]           st_data_o
);

  localparam logic [2:0] LP_GNT_WAIT = 3'(GNT_WAIT);

  if (GNT_WAIT > GNT_WAIT_MAX) begin : g_bad_gnt_wait
    $error("GNT_WAIT out of range");
  end
  if (RSP_LAT < RSP_LAT_MIN || RSP_LAT > RSP_LAT_MAX) begin : g_bad_rsp_lat
    $error("RSP_LAT out of range");
  end

  logic [31:0]           r_mem [2**DEPTH_LOG2];
  gnt_state_e            r_state;
  logic [2:0]            r_wcnt;
  logic                  r_st_valid;
  logic [31:0]           r_st_addr;
  logic [31:0]           r_st_data;

  logic                  w_gnt;
  logic [31:0]           w_off;
  logic [29:0]           w_word;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_in_range;
  logic [31:0]           w_old;
  logic [31:0]           w_merged;
  logic                  w_store;
  mem_rsp_t              w_rsp_in;
  mem_rsp_t              w_rsp_out;

  // Preload and reset both veto the grant, so the RAM never sees two writers.
  always_comb begin
    w_gnt = 1'b0;
    if (rst_ni && data_req_i && !init_we_i) begin
      if (GNT_WAIT == 0) w_gnt = 1'b1;
      else               w_gnt = (r_state == S_WAIT) && (r_wcnt == LP_GNT_WAIT);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else if (GNT_WAIT != 0) begin
      case (r_state)
        S_IDLE: begin
          if (data_req_i) begin
            r_state <= S_WAIT;
            r_wcnt  <= 3'd1;
          end
        end
        S_WAIT: begin
          if (w_gnt || !data_req_i) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
          end else if (!init_we_i && r_wcnt != LP_GNT_WAIT) begin
            r_wcnt <= r_wcnt + 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wcnt  <= '0;
        end
      endcase
    end
  end

  assign w_off      = data_addr_i - BASE_ADDR;
  assign w_word     = w_off[31:2];
  assign w_in_range = (w_word >> DEPTH_LOG2) == '0;
  assign w_idx      = w_word[DEPTH_LOG2-1:0];
  assign w_old      = r_mem[w_idx];
  assign w_merged   = be_merge(w_old, data_wdata_i, data_be_i);
  assign w_store    = w_gnt && data_we_i && w_in_range;

  always_ff @(posedge clk) begin
    if (init_we_i)    r_mem[init_addr_i] <= init_wdata_i;
    else if (w_store) r_mem[w_idx]       <= w_merged;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_st_valid <= 1'b0;
      r_st_addr  <= '0;
      r_st_data  <= '0;
    end else begin
      r_st_valid <= w_store;
      if (w_store) begin
        r_st_addr <= {data_addr_i[31:2], 2'b00};
        r_st_data <= w_merged;
      end
    end
  end

  always_comb begin
    w_rsp_in       = '0;
    w_rsp_in.valid = w_gnt;
    w_rsp_in.err   = w_gnt && !w_in_range;
    if (w_gnt && w_in_range && !data_we_i) w_rsp_in.rdata = w_old;
  end

  riscy_mem_rsp_pipe #(
    .RSP_LAT(RSP_LAT)
  ) u_rsp_pipe (
    .clk   (clk),
    .rst_ni(rst_ni),
    .i_rsp (w_rsp_in),
    .o_rsp (w_rsp_out)
  );

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = w_rsp_out.valid;
  assign data_err_o    = w_rsp_out.err;
  assign data_rdata_o  = w_rsp_out.rdata;
  assign st_valid_o    = r_st_valid;
  assign st_addr_o     = r_st_addr;
  assign st_data_o     = r_st_data;

endmodule

// File: tb/tb_riscy_obi_mem_responder.sv
// Directed bench: three responder instances (A: wait0/lat2, B: wait3/lat1,
// C: wait0/lat3) share one set of inputs; each test targets one instance.
module tb_riscy_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        init_we = 1'b0;
  logic [9:0]  init_addr = '0;
  logic [31:0] init_wdata = '0;

  logic        gnt_a, rvalid_a, err_a, st_valid_a;
  logic [31:0] rdata_a, st_addr_a, st_data_a;
  logic        gnt_b, rvalid_b, err_b, st_valid_b;
  logic [31:0] rdata_b, st_addr_b, st_data_b;
  logic        gnt_c, rvalid_c, err_c, st_valid_c;
  logic [31:0] rdata_c, st_addr_c, st_data_c;

  int checks = 0;
  int failures = 0;
  logic [31:0] vals [4] = '{32'hC0DE0000, 32'hC0DE1111, 32'hC0DE2222, 32'hC0DE3333};

  always #5 clk = ~clk;

  riscy_obi_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .GNT_WAIT(0), .RSP_LAT(2)) u_dut_a (
    .clk(clk), .rst_ni(rst_ni), .data_req_i(req), .data_gnt_o(gnt_a), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid_a),
    .data_rdata_o(rdata_a), .data_err_o(err_a), .init_we_i(init_we), .init_addr_i(init_addr),
    .init_wdata_i(init_wdata), .st_valid_o(st_valid_a), .st_addr_o(st_addr_a), .st_data_o(st_data_a));

  riscy_obi_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .GNT_WAIT(3), .RSP_LAT(1)) u_dut_b (
    .clk(clk), .rst_ni(rst_ni), .data_req_i(req), .data_gnt_o(gnt_b), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid_b),
    .data_rdata_o(rdata_b), .data_err_o(err_b), .init_we_i(init_we), .init_addr_i(init_addr),
    .init_wdata_i(init_wdata), .st_valid_o(st_valid_b), .st_addr_o(st_addr_b), .st_data_o(st_data_b));

  riscy_obi_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .GNT_WAIT(0), .RSP_LAT(3)) u_dut_c (
    .clk(clk), .rst_ni(rst_ni), .data_req_i(req), .data_gnt_o(gnt_c), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid_c),
    .data_rdata_o(rdata_c), .data_err_o(err_c), .init_we_i(init_we), .init_addr_i(init_addr),
    .init_wdata_i(init_wdata), .st_valid_o(st_valid_c), .st_addr_o(st_addr_c), .st_data_o(st_data_c));

  // Inputs change just after a rising edge; outputs are checked on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0; init_we = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    init_we = 1'b1; init_addr = idx; init_wdata = val;
    cyc();
    init_we = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    req = 1'b1; we = 1'b0; addr = 32'h0;
    repeat (2) cyc();
    mid();
    checks++; if (gnt_a !== 1'b0) begin failures++; $display("FAIL rst_gnt_a got=%h exp=0", gnt_a); end
    checks++; if (gnt_c !== 1'b0) begin failures++; $display("FAIL rst_gnt_c got=%h exp=0", gnt_c); end
    checks++; if (rvalid_a !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%h exp=0", rvalid_a); end
    checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL rst_err got=%h exp=0", err_a); end
    checks++; if (st_valid_a !== 1'b0) begin failures++; $display("FAIL rst_st_valid got=%h exp=0", st_valid_a); end
    checks++; if (st_addr_a !== 32'h0) begin failures++; $display("FAIL rst_st_addr got=%h exp=0", st_addr_a); end
    checks++; if (st_data_a !== 32'h0) begin failures++; $display("FAIL rst_st_data got=%h exp=0", st_data_a); end
    cyc();
    rst_ni = 1'b1;
    mid();
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL post_rst_gnt got=%h exp=1", gnt_a); end
    cyc();
    req = 1'b0;
    mid();
    checks++; if (gnt_a !== 1'b0) begin failures++; $display("FAIL gnt_follows_req got=%h exp=0", gnt_a); end
    idle(4);
  endtask

  task automatic test_preload_read();
    preload(10'd5, 32'hDEADBEEF);
    req = 1'b1; we = 1'b0; addr = 32'h14; be = 4'h0;
    mid();
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL pl_gnt got=%h exp=1", gnt_a); end
    cyc();
    req = 1'b0;
    mid();
    checks++; if (rvalid_a !== 1'b0) begin failures++; $display("FAIL pl_rvalid_early got=%h exp=0", rvalid_a); end
    cyc();
    mid();
    checks++; if (rvalid_a !== 1'b1) begin failures++; $display("FAIL pl_rvalid got=%h exp=1", rvalid_a); end
    checks++; if (rdata_a !== 32'hDEADBEEF) begin failures++; $display("FAIL pl_rdata got=%h exp=deadbeef", rdata_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL pl_err got=%h exp=0", err_a); end
    cyc();
    mid();
    checks++; if (rvalid_a !== 1'b0) begin failures++; $display("FAIL pl_rvalid_pulse got=%h exp=0", rvalid_a); end
    idle(3);
  endtask

  task automatic test_be_store();
    preload(10'd0, 32'h11223344);
    req = 1'b1; we = 1'b1; be = 4'b0101; addr = 32'h0; wdata = 32'hAABBCCDD;
    mid();
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL st_gnt got=%h exp=1", gnt_a); end
    cyc();
    req = 1'b0; we = 1'b0;
    mid();
    checks++; if (st_valid_a !== 1'b1) begin failures++; $display("FAIL st_valid got=%h exp=1", st_valid_a); end
    checks++; if (st_data_a !== 32'h11BB33DD) begin failures++; $display("FAIL st_data got=%h exp=11bb33dd", st_data_a); end
    checks++; if (st_addr_a !== 32'h0) begin failures++; $display("FAIL st_addr got=%h exp=0", st_addr_a); end
    cyc();
    mid();
    checks++; if (st_valid_a !== 1'b0) begin failures++; $display("FAIL st_valid_pulse got=%h exp=0", st_valid_a); end
    checks++; if (rvalid_a !== 1'b1) begin failures++; $display("FAIL st_rsp_valid got=%h exp=1", rvalid_a); end
    checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL st_rsp_rdata got=%h exp=0", rdata_a); end
    cyc();
    req = 1'b1; we = 1'b1; be = 4'b0000; wdata = 32'hFFFFFFFF;
    mid();
    cyc();
    req = 1'b1; we = 1'b0;
    mid();
    checks++; if (st_valid_a !== 1'b1) begin failures++; $display("FAIL be0_st_valid got=%h exp=1", st_valid_a); end
    checks++; if (st_data_a !== 32'h11BB33DD) begin failures++; $display("FAIL be0_st_data got=%h exp=11bb33dd", st_data_a); end
    cyc();
    req = 1'b0;
    mid();
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h0) begin failures++; $display("FAIL be0_rsp got=%h/%h exp=1/0", rvalid_a, rdata_a); end
    cyc();
    mid();
    checks++; if (rvalid_a !== 1'b1) begin failures++; $display("FAIL rd_merged_valid got=%h exp=1", rvalid_a); end
    checks++; if (rdata_a !== 32'h11BB33DD) begin failures++; $display("FAIL rd_merged got=%h exp=11bb33dd", rdata_a); end
    idle(3);
  endtask

  task automatic test_grant_wait();
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; we = 1'b0; addr = 32'h14;
      mid();
      checks++; if (gnt_b !== (i == 3)) begin failures++; $display("FAIL gw_hold_c%0d got=%h exp=%h", i, gnt_b, (i == 3)); end
      cyc();
    end
    req = 1'b0;
    mid();
    checks++; if (rvalid_b !== 1'b1 || rdata_b !== 32'hDEADBEEF) begin failures++; $display("FAIL gw_rsp got=%h/%h exp=1/deadbeef", rvalid_b, rdata_b); end
    cyc();
    for (int i = 0; i < 2; i++) begin
      req = 1'b1;
      mid();
      checks++; if (gnt_b !== 1'b0) begin failures++; $display("FAIL gw_abort_c%0d got=%h exp=0", i, gnt_b); end
      cyc();
    end
    req = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      req = 1'b1;
      mid();
      checks++; if (gnt_b !== (i == 3)) begin failures++; $display("FAIL gw_restart_c%0d got=%h exp=%h", i, gnt_b, (i == 3)); end
      cyc();
    end
    req = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      req = 1'b1; init_we = (i == 3); init_addr = 10'd100; init_wdata = 32'h0;
      mid();
      checks++; if (gnt_b !== (i == 4)) begin failures++; $display("FAIL gw_init_c%0d got=%h exp=%h", i, gnt_b, (i == 4)); end
      if (i == 3) begin
        checks++; if (gnt_a !== 1'b0) begin failures++; $display("FAIL init_blocks_gnt_a got=%h exp=0", gnt_a); end
      end
      cyc();
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) preload(10'(i), vals[i]);
    for (int i = 0; i < 8; i++) begin
      req = (i < 4); we = 1'b0; addr = 32'(4 * i);
      mid();
      if (i < 4) begin
        checks++; if (gnt_c !== 1'b1) begin failures++; $display("FAIL b2b_gnt_c%0d got=%h exp=1", i, gnt_c); end
      end
      if (i >= 3 && i <= 6) begin
        checks++; if (rvalid_c !== 1'b1 || rdata_c !== vals[i-3]) begin failures++; $display("FAIL b2b_rsp_c%0d got=%h/%h exp=1/%h", i, rvalid_c, rdata_c, vals[i-3]); end
      end else begin
        checks++; if (rvalid_c !== 1'b0) begin failures++; $display("FAIL b2b_idle_c%0d got=%h exp=0", i, rvalid_c); end
      end
      cyc();
    end
    idle(3);
  endtask

  task automatic test_oob_reset();
    req = 1'b1; we = 1'b0; addr = 32'h0000_1000;
    mid();
    cyc();
    req = 1'b1; we = 1'b1; be = 4'hF; wdata = 32'h12345678; addr = 32'h0000_1000;
    mid();
    cyc();
    req = 1'b1; we = 1'b0; addr = 32'h0;
    mid();
    checks++; if (st_valid_a !== 1'b0) begin failures++; $display("FAIL oob_st_valid got=%h exp=0", st_valid_a); end
    checks++; if (rvalid_a !== 1'b1 || err_a !== 1'b1 || rdata_a !== 32'h0) begin failures++; $display("FAIL oob_rd_rsp got=%h/%h/%h exp=1/1/0", rvalid_a, err_a, rdata_a); end
    cyc();
    req = 1'b0;
    mid();
    checks++; if (rvalid_a !== 1'b1 || err_a !== 1'b1 || rdata_a !== 32'h0) begin failures++; $display("FAIL oob_wr_rsp got=%h/%h/%h exp=1/1/0", rvalid_a, err_a, rdata_a); end
    cyc();
    mid();
    checks++; if (rvalid_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== vals[0]) begin failures++; $display("FAIL oob_ram_untouched got=%h/%h/%h exp=1/0/%h", rvalid_a, err_a, rdata_a, vals[0]); end
    idle(4);
    req = 1'b1; addr = 32'h4;
    cyc();
    req = 1'b1; addr = 32'h8;
    cyc();
    req = 1'b0; rst_ni = 1'b0;
    mid();
    checks++; if (rvalid_a !== 1'b0) begin failures++; $display("FAIL midrst_a got=%h exp=0", rvalid_a); end
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      checks++; if (rvalid_c !== 1'b0) begin failures++; $display("FAIL midrst_c%0d got=%h exp=0", i, rvalid_c); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_be_store();
    test_grant_wait();
    test_back_to_back();
    test_oob_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
